// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: instruction-memory request/ack channel plus the decode-side valid/ready queue head.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [31:0]   out_pc_plus4;
  logic [CW-1:0] count;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, count,
    input  imem_ack, imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, count,
    output imem_ack, imem_rdata, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding word read at a time,
// and buffers {instr, pc} pairs in a small FIFO toward decode; redirect flushes and restarts.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          redirect,
  input  logic [31:0]   redirect_target,
  fetch_queue_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        r_state, w_state_next;
  logic [31:0]   r_fetch_pc, w_fetch_pc_next;
  logic [31:0]   r_addr, w_addr_next;
  logic          r_req, w_req_next;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [31:0]   r_fifo_pc    [DEPTH];

  logic [31:0]   w_target;
  logic          w_ack, w_pop, w_push, w_flush;
  logic [CW-1:0] w_count_ack;

  assign w_target    = redirect_target & 32'hFFFF_FFFC;
  assign w_ack       = r_req & bus.imem_ack;
  // A pop coinciding with a redirect is swallowed by the flush.
  assign w_pop       = (r_count != '0) & bus.out_ready & ~redirect;
  assign w_count_ack = r_count + CW'(1) - CW'(w_pop);

  // Next-state and request control.
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_addr_next     = r_addr;
    w_req_next      = r_req;
    w_push          = 1'b0;
    w_flush         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (redirect) begin
          w_flush         = 1'b1;
          w_fetch_pc_next = w_target;
        end else if (r_count < CW'(DEPTH)) begin
          w_state_next = S_WAIT;
          w_req_next   = 1'b1;
          w_addr_next  = r_fetch_pc;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          w_flush         = 1'b1;
          w_fetch_pc_next = w_target;
          if (w_ack) begin
            w_state_next = S_IDLE;
            w_req_next   = 1'b0;
          end else begin
            w_state_next = S_DROP;
          end
        end else if (w_ack) begin
          w_push          = 1'b1;
          w_fetch_pc_next = r_addr + 32'd4;
          // Back-to-back fetch only while the pushed entry leaves room.
          if (w_count_ack < CW'(DEPTH)) begin
            w_addr_next = r_addr + 32'd4;
          end else begin
            w_state_next = S_IDLE;
            w_req_next   = 1'b0;
          end
        end
      end
      S_DROP: begin
        if (redirect) begin
          w_flush         = 1'b1;
          w_fetch_pc_next = w_target;
        end
        if (w_ack) begin
          w_state_next = S_IDLE;
          w_req_next   = 1'b0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_addr     <= w_addr_next;
      r_req      <= w_req_next;
      if (w_flush) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clock) begin
    if (w_push && !reset) begin
      r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
      r_fifo_pc[r_wr_ptr]    <= r_addr;
    end
  end

  assign bus.imem_req     = r_req;
  assign bus.imem_addr    = r_addr;
  assign bus.count        = r_count;
  assign bus.out_valid    = (r_count != '0);
  assign bus.out_instr    = r_fifo_instr[r_rd_ptr];
  assign bus.out_pc       = r_fifo_pc[r_rd_ptr];
  assign bus.out_pc_plus4 = r_fifo_pc[r_rd_ptr] + 32'd4;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic checked against a queue-based model.
module tb_fetch_queue;
  localparam logic [31:0] K     = 32'hA5A5_A5A5;
  localparam int          DEPTH = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset   = 1'b1;
  logic        rst_b   = 1'b1;
  logic        rdy_a   = 1'b0;
  logic        redir_a = 1'b0;
  logic [31:0] tgt_a   = 32'h0;
  logic        mem_en  = 1'b1;
  logic        man_ack = 1'b0;

  fetch_queue_if #(.DEPTH(DEPTH)) ifa ();
  fetch_queue_if #(.DEPTH(DEPTH)) ifb ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut_a (
    .clock(clock), .reset(reset), .redirect(redir_a), .redirect_target(tgt_a), .bus(ifa)
  );
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clock(clock), .reset(rst_b), .redirect(1'b0), .redirect_target(32'h0), .bus(ifb)
  );

  // Memory for dut_a: acks after lat_a extra cycles; random latency when rand_lat is set.
  int          lat_a    = 0;
  int          age_a    = 0;
  bit          rand_lat = 1'b0;
  logic        mem_ack  = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  always @(negedge clock) begin
    if (ifa.imem_req) begin
      if (age_a >= lat_a) begin
        mem_ack   = 1'b1;
        mem_rdata = ifa.imem_addr ^ K;
        age_a     = 0;
        if (rand_lat) lat_a = $urandom_range(0, 2);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        age_a++;
      end
    end else begin
      mem_ack = 1'b0;
      age_a   = 0;
    end
  end
  assign ifa.imem_ack   = mem_en ? mem_ack : man_ack;
  assign ifa.imem_rdata = mem_rdata;
  assign ifa.out_ready  = rdy_a;

  // Zero-wait memory for dut_b.
  assign ifb.imem_ack   = ifb.imem_req;
  assign ifb.imem_rdata = ifb.imem_addr ^ K;
  assign ifb.out_ready  = 1'b1;

  int tests = 0;
  int fails = 0;

  // Model: PCs of accepted fetches awaiting decode, next expected fetch address, stale-request flag.
  logic [31:0] q[$];
  logic [31:0] exp_fetch = 32'h0;
  bit          stale     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic rst, input logic rdy, input logic redir, input logic [31:0] tgt);
    logic        p_rst, p_req, p_ack, p_valid, p_pop, p_redir, exp_req;
    logic [31:0] p_addr;
    int          p_cnt;
    @(negedge clock);
    reset = rst; rdy_a = rdy; redir_a = redir; tgt_a = tgt;
    #1;
    p_rst = rst; p_redir = redir;
    p_req = ifa.imem_req; p_ack = ifa.imem_ack; p_addr = ifa.imem_addr;
    p_valid = ifa.out_valid; p_pop = p_valid && rdy; p_cnt = q.size();
    chk("pre_valid", 32'(p_valid), 32'(q.size() != 0));
    if (p_pop && !p_redir && !p_rst) begin
      if (q.size() > 0) begin
        chk("out_pc", ifa.out_pc, q[0]);
        chk("out_instr", ifa.out_instr, q[0] ^ K);
        chk("out_pc_plus4", ifa.out_pc_plus4, q[0] + 32'd4);
      end else begin
        chk("pop_nonempty", 32'(q.size()), 32'd1);
      end
    end
    @(posedge clock);
    #1;
    if (p_rst) begin
      q.delete(); stale = 1'b0; exp_fetch = 32'h0;
      chk("rst_req", 32'(ifa.imem_req), 32'd0);
      chk("rst_addr", ifa.imem_addr, 32'h0);
    end else if (p_redir) begin
      q.delete();
      exp_fetch = tgt & 32'hFFFF_FFFC;
      stale = p_req && !p_ack;
      if (stale) begin
        chk("redir_hold_req", 32'(ifa.imem_req), 32'd1);
        chk("redir_hold_addr", ifa.imem_addr, p_addr);
      end else begin
        chk("redir_no_req", 32'(ifa.imem_req), 32'd0);
      end
    end else begin
      if (p_pop) void'(q.pop_front());
      if (p_req && p_ack && !stale) begin
        chk("push_addr", p_addr, exp_fetch);
        q.push_back(p_addr);
        exp_fetch = exp_fetch + 32'd4;
        exp_req = (q.size() < DEPTH);
        chk("req_after_ack", 32'(ifa.imem_req), 32'(exp_req));
        if (exp_req) chk("b2b_addr", ifa.imem_addr, exp_fetch);
      end else if (p_req && p_ack) begin
        stale = 1'b0;
        chk("drop_req", 32'(ifa.imem_req), 32'd0);
      end else if (p_req) begin
        chk("hold_req", 32'(ifa.imem_req), 32'd1);
        chk("hold_addr", ifa.imem_addr, p_addr);
      end else begin
        exp_req = (p_cnt < DEPTH);
        chk("issue_req", 32'(ifa.imem_req), 32'(exp_req));
        if (exp_req) chk("issue_addr", ifa.imem_addr, exp_fetch);
      end
    end
    chk("count", 32'(ifa.count), 32'(q.size()));
    chk("valid", 32'(ifa.out_valid), 32'(q.size() != 0));
  endtask

  initial begin
    logic        r_rdy, r_redir, r_rst;
    logic [31:0] r_tgt;

    // 1: zero-wait memory, streaming
    lat_a = 0; rand_lat = 1'b0;
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    chk("t1_rst_count", 32'(ifa.count), 32'd0);
    chk("t1_rst_valid", 32'(ifa.out_valid), 32'd0);
    step(0, 1, 0, 0);
    chk("t1_valid_c1", 32'(ifa.out_valid), 32'd0);
    chk("t1_addr_c1", ifa.imem_addr, 32'h0);
    step(0, 1, 0, 0);
    chk("t1_valid_c2", 32'(ifa.out_valid), 32'd1);
    chk("t1_pc_c2", ifa.out_pc, 32'h0);
    chk("t1_addr_c2", ifa.imem_addr, 32'h4);
    step(0, 1, 0, 0);
    chk("t1_pc_c3", ifa.out_pc, 32'h4);
    chk("t1_instr_c3", ifa.out_instr, 32'h4 ^ K);
    chk("t1_addr_c3", ifa.imem_addr, 32'h8);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);

    // 2: decode stalled fills the queue, then resumes
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    chk("t2_count_full", 32'(ifa.count), 32'd4);
    chk("t2_req_off", 32'(ifa.imem_req), 32'd0);
    chk("t2_head", ifa.out_pc, 32'h0);
    for (int i = 0; i < 8 && !ifa.imem_req; i++) step(0, 1, 0, 0);
    chk("t2_resume_req", 32'(ifa.imem_req), 32'd1);
    chk("t2_resume_addr", ifa.imem_addr, 32'h10);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);

    // 3: slow memory, redirect while waiting
    lat_a = 3;
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(0, 1, 1, 32'h0000_0103);
    chk("t3_hold_req", 32'(ifa.imem_req), 32'd1);
    chk("t3_hold_addr", ifa.imem_addr, 32'h0);
    for (int i = 0; i < 8 && !(ifa.imem_req && ifa.imem_addr != 32'h0); i++) begin
      step(0, 1, 0, 0);
      chk("t3_empty", 32'(ifa.count), 32'd0);
    end
    chk("t3_new_addr", ifa.imem_addr, 32'h0000_0100);
    for (int i = 0; i < 8 && !ifa.out_valid; i++) step(0, 1, 0, 0);
    chk("t3_first_pc", ifa.out_pc, 32'h0000_0100);
    step(0, 1, 0, 0);

    // 4: redirect coincident with ack of addr 8
    lat_a = 0;
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
    chk("t4_addr8", ifa.imem_addr, 32'h8);
    step(0, 1, 1, 32'h40);
    chk("t4_flush_count", 32'(ifa.count), 32'd0);
    chk("t4_no_req", 32'(ifa.imem_req), 32'd0);
    step(0, 1, 0, 0);
    chk("t4_req_40", ifa.imem_addr, 32'h40);
    for (int i = 0; i < 4 && !ifa.out_valid; i++) step(0, 1, 0, 0);
    chk("t4_first_pc", ifa.out_pc, 32'h40);

    // 5: wraparound on the second instance while the first is held in reset
    rst_b = 1'b0;
    step(1, 0, 0, 0);
    chk("t5_addr_c1", ifb.imem_addr, 32'hFFFF_FFF8);
    chk("t5_valid_c1", 32'(ifb.out_valid), 32'd0);
    step(1, 0, 0, 0);
    chk("t5_pc_c2", ifb.out_pc, 32'hFFFF_FFF8);
    chk("t5_instr_c2", ifb.out_instr, 32'hFFFF_FFF8 ^ K);
    step(1, 0, 0, 0);
    chk("t5_pc_c3", ifb.out_pc, 32'hFFFF_FFFC);
    chk("t5_p4_c3", ifb.out_pc_plus4, 32'h0);
    step(1, 0, 0, 0);
    chk("t5_pc_c4", ifb.out_pc, 32'h0);
    chk("t5_p4_c4", ifb.out_pc_plus4, 32'h4);
    chk("t5_count", 32'(ifb.count), 32'd1);

    // 6: reset mid-request, then a late ack
    step(1, 0, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("t6_count2", 32'(ifa.count), 32'd2);
    chk("t6_wait", 32'(ifa.imem_req), 32'd1);
    mem_en = 1'b0; man_ack = 1'b0;
    step(1, 0, 0, 0);
    chk("t6_req0", 32'(ifa.imem_req), 32'd0);
    chk("t6_count0", 32'(ifa.count), 32'd0);
    chk("t6_valid0", 32'(ifa.out_valid), 32'd0);
    man_ack = 1'b1;
    step(0, 0, 0, 0);
    chk("t6_late_count", 32'(ifa.count), 32'd0);
    chk("t6_late_addr", ifa.imem_addr, 32'h0);
    man_ack = 1'b0;
    step(0, 0, 0, 0);
    chk("t6_after_count", 32'(ifa.count), 32'd0);
    mem_en = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

    // Random traffic against the model
    rand_lat = 1'b1;
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      r_rst   = ($urandom_range(0, 199) == 0);
      r_rdy   = ($urandom_range(0, 3) != 0);
      r_redir = ($urandom_range(0, 11) == 0);
      r_tgt   = ($urandom_range(0, 1) == 1) ? 32'($urandom)
                                            : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      step(r_rst, r_rdy, r_redir, r_tgt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage between the program-counter logic and instruction decode.
- Owns the fetch PC, issues word reads to instruction memory over a req/ack handshake, and buffers returned instructions with their PC in a small FIFO.
- Presents instructions to decode through a valid/ready interface.
- A redirect (branch/jump target from the PC-update logic) flushes the queue and restarts fetch at the target.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, >=2).
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clock  input  1  system clock, all state on posedge
- reset  input  1  synchronous, active-high reset
- redirect  input  1  flush queue and restart fetch at redirect_target
- redirect_target  input  32  new fetch address; bits [1:0] ignored (forced 00)
- imem_req  output  1  read request to instruction memory (registered)
- imem_addr  output  32  word-aligned read address (registered)
- imem_ack  input  1  memory completes the current request this cycle
- imem_rdata  input  32  instruction word, valid when imem_ack=1
- out_valid  output  1  out_instr/out_pc hold a valid entry
- out_ready  input  1  decode consumes the head entry this cycle
- out_instr  output  32  head instruction word
- out_pc  output  32  address of head instruction
- out_pc_plus4  output  32  out_pc + 4, modulo 2^32
- count  output  clog2(DEPTH)+1  current number of FIFO entries

Behaviour:
- Reset, dominant over all other inputs:
  - state=IDLE, fetch_pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, count=0, out_valid=0.
  - FIFO pointers=0; out_instr/out_pc are don't-care while out_valid=0.
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; imem_req=1.
  - DROP: request outstanding; its data is to be discarded.
- Handshake:
  - imem_req and imem_addr stay stable from issue until the cycle imem_ack=1; a request completes on the cycle imem_ack=1.
  - imem_ack in IDLE is ignored.
  - At most one request is outstanding.
- IDLE->WAIT: when count < DEPTH and redirect=0. Drive imem_req=1 and imem_addr=fetch_pc.
- WAIT, ack, no redirect:
  - Push {imem_rdata, imem_addr} into the FIFO; fetch_pc = imem_addr + 4.
  - Compute count_next = count + 1 - pop. If count_next < DEPTH, stay in WAIT with imem_addr = imem_addr + 4 (back-to-back fetch). Otherwise go to IDLE with imem_req=0.
- WAIT, no ack, redirect=1:
  - Go to DROP; imem_req and imem_addr remain held for the old request.
  - fetch_pc = target; FIFO flushed.
- WAIT, ack and redirect in the same cycle:
  - Returned data discarded; FIFO flushed; fetch_pc = target; go to IDLE.
- DROP:
  - On ack, discard data and go to IDLE.
  - Redirect while in DROP updates fetch_pc only; the last redirect wins.
- IDLE, redirect=1: FIFO flushed, fetch_pc = target, no request this cycle.
- Flush: count=0, pointers=0, out_valid=0 on the next cycle. A pop in the redirect cycle is discarded.
- Output side:
  - out_valid = (count != 0).
  - Pop when out_valid && out_ready. Head entry advances the next cycle.
  - No bypass: data acked in cycle k is visible at the head no earlier than k+1.
  - Push and pop in the same cycle leave count unchanged.
  - Pop with out_valid=0 is ignored.
- Full: no new request is issued while count + outstanding >= DEPTH, so a push never overflows.
- Arithmetic: PC increments are modulo 2^32; 32'hFFFFFFFC + 4 = 32'h00000000.
- Latency: request issued in the cycle after the IDLE decision; a zero-wait memory (ack on the first req cycle) gives one instruction per cycle sustained while out_ready=1.

Test Plan:
1. Reset, then single-cycle ack memory returning instr = addr ^ 32'hA5A5A5A5, out_ready=1 -> imem_addr 0,4,8,... on consecutive cycles; out_pc 0,4,8 with matching instr; first out_valid 2 cycles after reset release.
2. out_ready=0 with DEPTH=4 -> exactly 4 pushes (PCs 0..C); imem_req drops; count=4. Release out_ready -> fetching resumes at 32'h10 with no gap or duplicate.
3. Memory acks 3 cycles after req; redirect to 32'h00000103 in the second wait cycle -> old request held until ack, its data dropped; next imem_addr=32'h00000100; queue empty until that instruction returns.
4. Redirect to 32'h40 in the same cycle as ack of addr 8 -> addr-8 data never appears at the output; next request at 32'h40.
5. RESET_PC=32'hFFFFFFF8, single-cycle ack -> out_pc FFFFFFF8, FFFFFFFC, 00000000; out_pc_plus4 of FFFFFFFC = 0.
6. Reset asserted while in WAIT with 2 entries queued -> next cycle imem_req=0, count=0, out_valid=0; a late ack arriving after reset is ignored.
